// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the program loader state encoding.
package fetch_pkg;

  localparam int DATA_W      = 36;
  localparam int ADDR_W      = 5;
  localparam int DEPTH       = 32;
  // Largest block a single load may write (one full pass of the memory).
  localparam int COUNT_LIMIT = DEPTH;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_WRITE  = 2'd1,
    LD_VERIFY = 2'd2,
    LD_DONE   = 2'd3
  } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Instruction stream plus program memory port of the program loader.
// master: the loader; slave: stream source and program memory.
interface program_loader_if
  import fetch_pkg::*;
#(
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int ADDR_W = fetch_pkg::ADDR_W
);

  logic [DATA_W-1:0] in_inst;
  logic              in_valid;
  logic              in_ready;
  logic              pm_wr;
  logic              pm_rd;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_wdata;
  logic [DATA_W-1:0] pm_rdata;

  modport master (
    input  in_inst, in_valid, pm_rdata,
    output in_ready, pm_wr, pm_rd, pm_addr, pm_wdata
  );

  modport slave (
    output in_inst, in_valid, pm_rdata,
    input  in_ready, pm_wr, pm_rd, pm_addr, pm_wdata
  );

endinterface

// File: rtl/pl_xor_accum.sv
// XOR checksum accumulator with synchronous clear (priority) and enable.
module pl_xor_accum
  import fetch_pkg::*;
#(
  parameter int DATA_W = fetch_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Clear wins over accumulate so a new block never inherits old words.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: writes a block of instructions from a valid/ready stream
// into program memory at sequential, wrapping addresses from a base, and
// holds the fetch stage off while doing so.
// Optional feature macro PROGRAM_LOADER_VERIFY_EN: read the block back after
// writing and flag a checksum mismatch on error.
module program_loader
  import fetch_pkg::*;
#(
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DEPTH  = fetch_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  program_loader_if.master  bus,
  output logic              fetch_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] S_IDLE   = LD_IDLE;
  localparam logic [1:0] S_WRITE  = LD_WRITE;
  localparam logic [1:0] S_VERIFY = LD_VERIFY;
  localparam logic [1:0] S_DONE   = LD_DONE;

  localparam logic [ADDR_W:0] CNT_LIMIT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   remain_q,    remain_d;
  logic              pm_wr_q,     pm_wr_d;
  logic [ADDR_W-1:0] pm_addr_q,   pm_addr_d;
  logic [DATA_W-1:0] pm_wdata_q,  pm_wdata_d;
  logic              error_q,     error_d;

  logic              start_acc;
  logic              beat;

  // A start is only honoured in IDLE; a beat needs a word still owed.
  assign start_acc    = (state_q == S_IDLE) && start;
  assign bus.in_ready = (state_q == S_WRITE) && (remain_q != '0);
  assign beat         = bus.in_ready && bus.in_valid;

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic              pm_rd_q,  pm_rd_d;
  logic              rd_vld_q;
  logic [DATA_W-1:0] wr_sum;
  logic [DATA_W-1:0] rd_sum;

  pl_xor_accum #(.DATA_W(DATA_W)) u_wr_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_acc),
    .en_i   (beat),
    .data_i (bus.in_inst),
    .acc_o  (wr_sum)
  );

  pl_xor_accum #(.DATA_W(DATA_W)) u_rd_sum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_acc),
    .en_i   (rd_vld_q),
    .data_i (bus.pm_rdata),
    .acc_o  (rd_sum)
  );

  // Block geometry is kept for the readback pass; rd_vld tracks read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      cnt_q    <= '0;
      pm_rd_q  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q <= base_addr;
        cnt_q  <= count;
      end
      pm_rd_q  <= pm_rd_d;
      rd_vld_q <= pm_rd_q;
    end
  end

  assign bus.pm_rd = pm_rd_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.pm_rdata;
  assign bus.pm_rd    = 1'b0;
`endif

  // Loader FSM: the last write and the last readback each get a drain cycle
  // with the request line low before moving on.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    pm_wr_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    error_d    = error_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
    pm_rd_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          error_d  = 1'b0;
          if (count == '0) begin
            state_d = S_DONE;
          end else if (count > CNT_LIMIT) begin
            state_d = S_DONE;
            error_d = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (remain_q != '0) begin
          if (bus.in_valid) begin
            pm_wr_d    = 1'b1;
            pm_addr_d  = addr_q;
            pm_wdata_d = bus.in_inst;
            addr_d     = addr_q + 1'b1;
            remain_d   = remain_q - 1'b1;
          end
        end else begin
`ifdef PROGRAM_LOADER_VERIFY_EN
          state_d   = S_VERIFY;
          pm_rd_d   = 1'b1;
          pm_addr_d = base_q;
          addr_d    = base_q + 1'b1;
          remain_d  = cnt_q - 1'b1;
`else
          state_d   = S_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (remain_q != '0) begin
          pm_rd_d   = 1'b1;
          pm_addr_d = addr_q;
          addr_d    = addr_q + 1'b1;
          remain_d  = remain_q - 1'b1;
        end else if (!pm_rd_q) begin
          // Last readback word is on pm_rdata now; fold it into the compare.
          state_d = S_DONE;
          if (wr_sum != (rd_sum ^ bus.pm_rdata)) begin
            error_d = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      pm_wr_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      pm_wr_q    <= pm_wr_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      error_q    <= error_d;
    end
  end

  assign bus.pm_wr    = pm_wr_q;
  assign bus.pm_addr  = pm_addr_q;
  assign bus.pm_wdata = pm_wdata_q;
  assign busy         = (state_q != S_IDLE);
  assign fetch_hold   = busy;
  assign done         = (state_q == S_DONE);
  assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Follows PROGRAM_LOADER_VERIFY_EN.
module tb_program_loader;
  import fetch_pkg::*;

`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        base_addr = '0;
  logic [5:0]        count = '0;
  logic              fetch_hold, busy, done, error;
  logic [35:0]       in_inst = '0;
  logic              in_valid = 1'b0;
  logic [35:0]       rdata = '0;
  logic              corrupt = 1'b0;
  logic [35:0]       mem [32];

  int n_chk = 0;
  int n_fail = 0;

  // results of the last run_load
  int          wr_cnt, rd_cnt, rd_first, rd_last, done_cyc, overlap;
  logic        done_err, busy_c1, busy_post;
  int          wr_cyc [64];
  logic [4:0]  wr_addr [64];
  logic [35:0] wr_data [64];

  program_loader_if bus ();

  assign bus.in_inst  = in_inst;
  assign bus.in_valid = in_valid;
  assign bus.pm_rdata = rdata;

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .bus        (bus),
    .fetch_hold (fetch_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // program memory model; readback of address 2 optionally corrupted
  always @(posedge clk) begin
    if (bus.pm_wr) mem[bus.pm_addr] <= bus.pm_wdata;
    if (bus.pm_rd) rdata <= mem[bus.pm_addr] ^ ((corrupt && bus.pm_addr == 5'd2) ? 36'h1 : 36'h0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] word(input logic [35:0] salt, input int i);
    return salt ^ (36'(i + 1) * 36'h1_0000_0001);
  endfunction

  function automatic int exp_done(input int n);
    return VFY ? (2 * n + 3) : (n + 2);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 0);
    check_eq({tag, "_pm_wr"}, bus.pm_wr, 0);
    check_eq({tag, "_pm_rd"}, bus.pm_rd, 0);
    check_eq({tag, "_busy_hold"}, {busy, fetch_hold}, 0);
    check_eq({tag, "_done_err"}, {done, error}, 0);
    check_eq({tag, "_pm_addr"}, bus.pm_addr, 0);
    check_eq({tag, "_pm_wdata"}, bus.pm_wdata, 0);
  endtask

  // One load; cycle k is the cycle after edge k-1, start sampled at edge 0.
  task automatic run_load(input logic [4:0] b, input logic [5:0] c, input int gap,
                          input int restart_at, input int abort_at, input logic [35:0] salt);
    int wi, idle;
    bit seen_done;
    wr_cnt = 0; rd_cnt = 0; rd_first = -1; rd_last = -1; done_cyc = -1; overlap = 0;
    done_err = 1'bx; busy_c1 = 1'b0; busy_post = 1'bx;
    wi = 0; idle = 0; seen_done = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c; in_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == restart_at) begin
        start = 1'b1; base_addr = 5'd20; count = 6'd1;
      end
      if (k == 1) busy_c1 = busy;
      if (bus.pm_wr && wr_cnt < 64) begin
        wr_cyc[wr_cnt] = k; wr_addr[wr_cnt] = bus.pm_addr; wr_data[wr_cnt] = bus.pm_wdata;
        wr_cnt++;
      end
      if (bus.pm_rd) begin
        if (rd_first < 0) rd_first = k;
        rd_last = k; rd_cnt++;
      end
      if (bus.pm_wr && bus.pm_rd) overlap++;
      if (seen_done) begin
        busy_post = busy;
        break;
      end
      if (done) begin
        seen_done = 1; done_cyc = k; done_err = error;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        break;
      end
      if (idle > 0) begin
        in_valid = 1'b0; idle--;
      end else begin
        in_valid = (wi < int'(c)); in_inst = word(salt, wi);
      end
      if (in_valid && bus.in_ready) begin
        wi++; idle = gap;
      end
    end
    in_valid = 1'b0;
    if (abort_at == 0) check_eq("done_seen", seen_done, 1);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic load base 0, count 4
    run_load(5'd0, 6'd4, 0, 0, 0, 36'h0);
    check_eq("basic_wr_cnt", wr_cnt, 4);
    check_eq("basic_first_wr", wr_cyc[0], 2);
    check_eq("basic_last_wr", wr_cyc[3], 5);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("basic_addr%0d", i), wr_addr[i], i);
      check_eq($sformatf("basic_data%0d", i), wr_data[i], (i + 1) * 36'h1_0000_0001);
      check_eq($sformatf("basic_mem%0d", i), mem[i], (i + 1) * 36'h1_0000_0001);
    end
    check_eq("basic_done_cyc", done_cyc, exp_done(4));
    check_eq("basic_error", done_err, 0);
    check_eq("basic_busy_c1", busy_c1, 1);
    check_eq("basic_busy_after", busy_post, 0);
    check_eq("basic_overlap", overlap, 0);
    if (VFY) begin
      check_eq("basic_rd_cnt", rd_cnt, 4);
      check_eq("basic_rd_first", rd_first, 6);
      check_eq("basic_rd_last", rd_last, 9);
    end else begin
      check_eq("basic_rd_cnt", rd_cnt, 0);
    end

    // wrap: base 30, count 4
    run_load(5'd30, 6'd4, 0, 0, 0, 36'h5_A5A5_0000);
    check_eq("wrap_wr_cnt", wr_cnt, 4);
    check_eq("wrap_addr0", wr_addr[0], 30);
    check_eq("wrap_addr1", wr_addr[1], 31);
    check_eq("wrap_addr2", wr_addr[2], 0);
    check_eq("wrap_addr3", wr_addr[3], 1);
    check_eq("wrap_data3", wr_data[3], 36'h5_A5A5_0000 ^ 36'h4_0000_0004);
    check_eq("wrap_done_cyc", done_cyc, exp_done(4));
    check_eq("wrap_error", done_err, 0);

    // backpressure: count 3, two idle cycles after every beat
    run_load(5'd8, 6'd3, 2, 0, 0, 36'h0_0F0F_0F00);
    check_eq("bp_wr_cnt", wr_cnt, 3);
    check_eq("bp_wr_cyc0", wr_cyc[0], 2);
    check_eq("bp_wr_cyc1", wr_cyc[1], 5);
    check_eq("bp_wr_cyc2", wr_cyc[2], 8);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("bp_addr%0d", i), wr_addr[i], 8 + i);
      check_eq($sformatf("bp_data%0d", i), wr_data[i], 36'h0_0F0F_0F00 ^ ((i + 1) * 36'h1_0000_0001));
    end
    check_eq("bp_done_cyc", done_cyc, VFY ? (8 + 3 + 2) : 9);
    check_eq("bp_error", done_err, 0);

    // bounds: count 33 then count 0
    run_load(5'd0, 6'd33, 0, 0, 0, 36'h0);
    check_eq("c33_done_cyc", done_cyc, 1);
    check_eq("c33_wr_cnt", wr_cnt, 0);
    check_eq("c33_error", done_err, 1);
    repeat (2) @(negedge clk);
    check_eq("c33_error_sticky", error, 1);
    run_load(5'd3, 6'd0, 0, 0, 0, 36'h0);
    check_eq("c0_done_cyc", done_cyc, 1);
    check_eq("c0_wr_cnt", wr_cnt, 0);
    check_eq("c0_error", done_err, 0);

    if (VFY) begin
      // readback of address 2 corrupted
      corrupt = 1'b1;
      run_load(5'd0, 6'd4, 0, 0, 0, 36'h0);
      corrupt = 1'b0;
      check_eq("vfy_bad_done_cyc", done_cyc, 11);
      check_eq("vfy_bad_error", done_err, 1);
      run_load(5'd0, 6'd4, 0, 0, 0, 36'h3_3333_0000);
      check_eq("vfy_good_done_cyc", done_cyc, 11);
      check_eq("vfy_good_error", done_err, 0);
    end

    // reset mid-load after the 2nd beat has been written
    run_load(5'd5, 6'd6, 0, 0, 4, 36'h7_0000_7000);
    check_eq("abort_mem5", mem[5], 36'h7_0000_7000 ^ 36'h1_0000_0001);
    check_eq("abort_mem6", mem[6], 36'h7_0000_7000 ^ 36'h2_0000_0002);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fresh load after reset, with a stray start pulse in cycle 2
    run_load(5'd10, 6'd3, 0, 2, 0, 36'h0);
    check_eq("rest_wr_cnt", wr_cnt, 3);
    check_eq("rest_addr0", wr_addr[0], 10);
    check_eq("rest_addr1", wr_addr[1], 11);
    check_eq("rest_addr2", wr_addr[2], 12);
    check_eq("rest_data2", wr_data[2], 36'h3_0000_0003);
    check_eq("rest_done_cyc", done_cyc, exp_done(3));
    check_eq("rest_error", done_err, 0);
    check_eq("rest_busy_after", busy_post, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a block of 36-bit instructions into the 32-entry program memory. Instructions arrive over a valid/ready stream and are written to sequential, wrapping addresses starting at a given base. It is the write-side counterpart of the instruction fetch path and drives the program memory write port (write enable, address, instruction) that fetch otherwise leaves idle. While loading it holds the fetch stage off, and it can optionally read the block back and check it.

## Interface
Parameters:
- DATA_W, 36, instruction width
- ADDR_W, 5, program memory address width
- DEPTH, 32, program memory entries (2**ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse that begins a load; honoured only in IDLE
- base_addr  in  ADDR_W  first write address, latched on start
- count  in  ADDR_W+1  number of words to load (0..32), latched on start
- in_inst  in  DATA_W  instruction stream data
- in_valid  in  1  stream data valid
- in_ready  out  1  loader accepts a word this cycle
- pm_wr  out  1  program memory write strobe
- pm_rd  out  1  program memory read strobe (verify only)
- pm_addr  out  ADDR_W  program memory address
- pm_wdata  out  DATA_W  program memory write data
- pm_rdata  in  DATA_W  program memory read data, valid the cycle after pm_rd
- fetch_hold  out  1  high while busy; fetch stage must not advance the PC
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky status, cleared by the next accepted start

## Operation
- States: IDLE, WRITE, VERIFY (only when the verify feature is compiled in), DONE.
- IDLE, start=1:
  - count and base_addr are latched.
  - count=0 goes to DONE with error=0 and performs no writes.
  - count>32 goes to DONE with error=1 and performs no writes.
  - Otherwise the loader enters WRITE.
- WRITE:
  - in_ready=1.
  - A beat transfers when in_valid&&in_ready at a clock edge.
  - Each beat is registered into pm_wdata/pm_addr with pm_wr=1 for exactly one cycle, then the address increments modulo 32.
  - After the count-th beat, in_ready drops that cycle and the FSM goes to VERIFY or DONE.
- Address wrap: base 30 with count 4 writes addresses 30, 31, 0, 1.
- VERIFY:
  - Re-reads the same count addresses from base, one pm_rd per cycle.
  - A 36-bit XOR checksum is accumulated over written words and, separately, over read words.
  - A mismatch sets error.
- DONE: done=1 for one cycle, then IDLE. error holds its value until the next accepted start.
- start while not in IDLE is ignored. Gaps in in_valid stall the loader without loss.
- busy=fetch_hold=1 in WRITE, VERIFY and DONE, and in the cycle carrying the final pm_wr.
- pm_wr and pm_rd are never high in the same cycle.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE; in_ready, pm_wr, pm_rd, busy, fetch_hold, done and error all 0; pm_addr and pm_wdata 0. Reset mid-load abandons the load, and words already written remain in memory.
- start sampled at edge 0. busy and in_ready are high from cycle 1.
- With in_valid held high for N words:
  - beats are accepted in cycles 1..N;
  - pm_wr is high in cycles 2..N+1 (write latency 1 cycle, throughput 1 word/cycle).
- Without verify: done is high in cycle N+2 and busy drops in cycle N+3.
- With verify:
  - pm_rd is high in cycles N+2..N+1+N;
  - the last pm_rdata arrives in cycle 2N+2;
  - done and the final error are valid in cycle 2N+3.
- count=0 or count>32: done in cycle 1.

## Configuration
- PROGRAM_LOADER_VERIFY_EN defined: the VERIFY state, pm_rd and the checksum logic are present, and error also reports readback mismatch.
- PROGRAM_LOADER_VERIFY_EN not defined: WRITE goes directly to DONE, pm_rd is tied to 0, pm_rdata is unused, and error reports only count>32.

## Structure
- Shared package fetch_pkg holds:
  - DATA_W=36, ADDR_W=5, DEPTH=32;
  - the loader state enum (IDLE, WRITE, VERIFY, DONE);
  - the count-limit constant.
- One sub-module, pl_xor_accum: a DATA_W-bit XOR accumulator with clear and enable. It is instantiated twice (write side and read side) and only when PROGRAM_LOADER_VERIFY_EN is defined.

## Test plan
- Basic load: base=0, count=4, words 0x1_0000_0001..0x4_0000_0004 with continuous valid -> pm_wr in cycles 2..5 to addresses 0..3, done in cycle 6, error=0, memory holds the words.
- Wrap: base=30, count=4 -> writes to 30, 31, 0, 1 in order, with no write to address 2.
- Backpressure: count=3 with in_valid low for 2 cycles between every beat -> exactly 3 pm_wr pulses with correct data, and done 1 cycle after the last pm_wr.
- Bounds: count=0 -> done in cycle 1, no pm_wr, error=0; count=33 -> done in cycle 1, no pm_wr, error=1.
- Verify (macro on): the memory model corrupts address 2 on readback, count=4 -> error=1 together with done in cycle 11; with no corruption -> error=0.
- Reset mid-load: rst_n low after the 2nd beat -> all outputs 0 at once; a new start after reset loads normally and start pulses during busy are ignored.
